// File: rtl/channel_mux_rr_pkg.sv
// Shared types and helpers for the channel_mux_rr slice: output FSM states,
// mode encodings and the channel-index wrap helper.
package channel_mux_rr_pkg;

    // Output stage occupancy; FULL is exactly out_valid=1
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } chmux_state_t;

    // Value of the mode input
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } chmux_mode_t;

    // Next channel after idx, wrapping n-1 back to 0
    function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/channel_mux_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting channel at or
// after ptr, modulo NCH. The pointer register is owned by the parent.
module rr_arbiter #(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt_onehot,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    // Rotating priority search starting at ptr
    always_comb begin
        int unsigned c;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            c = 32'(ptr) + k;
            if (c >= NCH) begin
                c = c - NCH;
            end
            if (!gnt_any && req[c]) begin
                gnt_any       = 1'b1;
                gnt_idx       = SELW'(c);
                gnt_onehot[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_mux_rr.sv
// N-channel registered multiplexer with valid/ready handshakes, fixed-address
// or round-robin channel selection, and a single skid-free output register.
// Optional feature macro: CHMUX_PARITY_EN adds the registered out_par output.
module channel_mux_rr
    import channel_mux_rr_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int WIDTH = 1,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SELW-1:0]      address,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef CHMUX_PARITY_EN
    ,
    output logic                 out_par
`endif
);

    chmux_state_t     state, state_nx;
    logic [SELW-1:0]  rr_ptr;

    logic [NCH-1:0]   rr_onehot;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;

    logic [NCH-1:0]   fix_onehot;
    logic [SELW-1:0]  fix_idx;
    logic             fix_any;

    logic [NCH-1:0]   gnt_onehot;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_any;

    logic             accept;
    logic             transfer;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .req        (in_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (rr_onehot),
        .gnt_idx    (rr_idx),
        .gnt_any    (rr_any)
    );

    // Fixed-mode grant: address must name an existing, valid channel
    always_comb begin
        fix_onehot = '0;
        fix_idx    = '0;
        fix_any    = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (32'(address) == i && in_valid[i]) begin
                fix_onehot[i] = 1'b1;
                fix_idx       = SELW'(i);
                fix_any       = 1'b1;
            end
        end
    end

    // Mode select and handshake; reset masks in_ready so nothing is taken
    // while the block is being cleared
    always_comb begin
        if (mode == MODE_RR) begin
            gnt_onehot = rr_onehot;
            gnt_idx    = rr_idx;
            gnt_any    = rr_any;
        end else begin
            gnt_onehot = fix_onehot;
            gnt_idx    = fix_idx;
            gnt_any    = fix_any;
        end
        accept   = !out_valid || out_ready;
        in_ready = reset ? '0 : (gnt_onehot & {NCH{accept}});
        transfer = !reset && gnt_any && accept;
    end

    // Granted channel's data word
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gnt_onehot[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Output FSM next state: fill on transfer, drain on out_ready without refill
    always_comb begin
        state_nx = state;
        case (state)
            ST_EMPTY: if (transfer) state_nx = ST_FULL;
            ST_FULL:  if (out_ready && !transfer) state_nx = ST_EMPTY;
            default:  state_nx = ST_EMPTY;
        endcase
    end

    assign out_valid = (state == ST_FULL);

    // Output word, channel id and rr pointer load only on a transfer, so a
    // stalled word is held regardless of mode/address changes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_chan <= '0;
            rr_ptr   <= '0;
        end else if (transfer) begin
            out_data <= sel_data;
            out_chan <= gnt_idx;
            rr_ptr   <= SELW'(wrap_inc(32'(gnt_idx), NCH));
        end
    end

`ifdef CHMUX_PARITY_EN
    // Even parity registered alongside out_data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_par <= 1'b0;
        end else if (transfer) begin
            out_par <= ^sel_data;
        end
    end
`endif

endmodule

// File: tb/tb_channel_mux_rr.sv
// Self-checking bench for channel_mux_rr (NCH=4, WIDTH=8) plus an NCH=5
// instance for out-of-range addressing. Honours CHMUX_PARITY_EN.
module tb_channel_mux_rr;

    localparam int NCH   = 4;
    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode;
    logic [1:0]  address;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic        b_mode;
    logic [2:0]  b_address;
    logic [39:0] b_in_data;
    logic [4:0]  b_in_valid;
    logic [4:0]  b_in_ready;
    logic [7:0]  b_out_data;
    logic [2:0]  b_out_chan;
    logic        b_out_valid;
    logic        b_out_ready;
`ifdef CHMUX_PARITY_EN
    logic        out_par;
    logic        b_out_par;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: contents of the output register and rr pointer
    logic       m_valid;
    logic [7:0] m_data;
    int         m_chan;
    int         m_ptr;

    channel_mux_rr #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .mode(mode), .address(address),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef CHMUX_PARITY_EN
        , .out_par(out_par)
`endif
    );

    channel_mux_rr #(.NCH(5), .WIDTH(8)) dut5 (
        .clk(clk), .reset(reset), .mode(b_mode), .address(b_address),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_chan(b_out_chan), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
`ifdef CHMUX_PARITY_EN
        , .out_par(b_out_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_ptr   = 0;
    endtask

    // Which channel the rules say is granted now (-1 for none)
    function automatic int exp_grant();
        int g;
        g = -1;
        if (mode == 1'b0) begin
            if (int'(address) < NCH && in_valid[address]) g = int'(address);
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && in_valid[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
            end
        end
        return g;
    endfunction

    // One clock: compare outputs at negedge, then advance the model over the posedge
    task automatic step();
        int         g;
        logic       acc;
        logic [3:0] er;
        @(negedge clk);
        g   = exp_grant();
        acc = !m_valid || out_ready;
        er  = (g >= 0 && acc) ? 4'(1 << g) : 4'b0000;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_chan",  32'(out_chan),  32'(m_chan));
        chk("in_ready",  32'(in_ready),  32'(er));
`ifdef CHMUX_PARITY_EN
        chk("out_par",   32'(out_par),   32'(^m_data));
`endif
        @(posedge clk);
        #1;
        if (g >= 0 && acc) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_chan  = g;
            m_ptr   = (g + 1) % NCH;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        mode = 1'b1; address = '0; in_data = '0; in_valid = '0; out_ready = 1'b1;
        b_mode = 1'b0; b_address = '0; b_in_data = 40'h5544332211; b_in_valid = '0;
        b_out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data",  32'(out_data),  32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd0);
        reset = 1'b0;

        // Round-robin over four always-valid channels
        mode = 1'b1; in_valid = 4'hF; in_data = 32'h44332211; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_seq_chan", 32'(out_chan), 32'(i % 4));
        end

        // Reset while a word is held
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_out_data",  32'(out_data),  32'd0);
        chk("midreset_in_ready",  32'(in_ready),  32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        step();
        chk("rr_first_after_reset", 32'(out_chan), 32'd0);

        // Fixed mode, address 2
        mode = 1'b0; address = 2'd2; in_valid = 4'hF; in_data = 32'h44A52211;
        #1;
        chk("fixed_in_ready", 32'(in_ready), 32'b0100);
        step();
        chk("fixed_data", 32'(out_data), 32'hA5);
        chk("fixed_chan", 32'(out_chan), 32'd2);

        // Out-of-range address on the five-channel instance
        b_in_valid = 5'h1F; b_address = 3'd5;
        #1 chk("nch5_addr5", 32'(b_in_ready), 32'd0);
        b_address = 3'd4;
        #1 chk("nch5_addr4", 32'(b_in_ready), 32'b10000);
        b_address = 3'd7;
        #1 chk("nch5_addr7", 32'(b_in_ready), 32'd0);

        // Sparse round-robin from a fresh pointer
        reset = 1'b1;
        #1 model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        mode = 1'b1; in_valid = 4'b1010; in_data = 32'hDDCCBBAA;
        step(); chk("sparse_a", 32'(out_chan), 32'd1);
        step(); chk("sparse_b", 32'(out_chan), 32'd3);
        step(); chk("sparse_c", 32'(out_chan), 32'd1);
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("single_chan",  32'(out_chan),  32'd1);
            chk("single_valid", 32'(out_valid), 32'd1);
        end

        // Backpressure with mode/address changing mid-stall
        out_ready = 1'b0; in_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                mode = 1'b0; address = 2'd3;
            end
            step();
            chk("stall_data",     32'(out_data), 32'hBB);
            chk("stall_chan",     32'(out_chan), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("resume_chan", 32'(out_chan), 32'd3);
        chk("resume_data", 32'(out_data), 32'hDD);

`ifdef CHMUX_PARITY_EN
        mode = 1'b0; address = 2'd0; in_valid = 4'b0001; in_data = 32'h07;
        step(); chk("parity_07", 32'(out_par), 32'd1);
        in_data = 32'h03;
        step(); chk("parity_03", 32'(out_par), 32'd0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            mode      = 1'($urandom_range(0, 1));
            address   = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
